// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer owning the HI/LO pair.
// mult/multu/div/divu run over WIDTH+2 cycles on one shared adder/subtractor;
// mthi/mtlo write HI/LO directly; rdata serves mfhi/mflo combinationally.
// Optional feature: define MULDIV_ABORT_EN to add an 'abort' input that
// cancels an in-flight operation (exception flush) without touching HI/LO.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Two's-complement magnitude when the value is negative, else unchanged.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
        if (neg) begin
            magnitude = {WIDTH{1'b0}} - v;
        end else begin
            magnitude = v;
        end
    endfunction

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] prod_r;     // MUL: {partial, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]   opb_r;      // MUL: |multiplicand|; DIV: |divisor|
    logic [WIDTH-1:0]   orig_a_r;   // raw dividend, returned in HI on divide-by-zero
    logic               op_div_r;
    logic               neg_res_r;  // negate product / quotient
    logic               neg_rem_r;  // negate remainder (dividend was negative)
    logic               dz_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               abort_s;
    logic               is_signed_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH:0]     add_a_s;
    logic [WIDTH:0]     add_b_s;
    logic               add_cin_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   hi_fix_s;
    logic [WIDTH-1:0]   lo_fix_s;

`ifdef MULDIV_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign busy  = busy_r;
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;

    // Read port for mfhi/mflo: LO only for mflo, HI otherwise.
    always_comb begin
        if (funct == F_MFLO) begin
            rdata = lo_r;
        end else begin
            rdata = hi_r;
        end
    end

    // Operand sign decode for the start cycle (even funct codes are signed).
    always_comb begin
        is_signed_s = ~funct[0];
        a_neg_s     = is_signed_s & srca[WIDTH-1];
        b_neg_s     = is_signed_s & srcb[WIDTH-1];
    end

    // Shared adder: add multiplicand in MUL, subtract divisor in DIV.
    always_comb begin
        if (state_r == S_DIV) begin
            add_a_s   = prod_r[2*WIDTH-1:WIDTH-1];
            add_b_s   = ~{1'b0, opb_r};
            add_cin_s = 1'b1;
        end else begin
            add_a_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
            if (prod_r[0]) begin
                add_b_s = {1'b0, opb_r};
            end else begin
                add_b_s = {(WIDTH+1){1'b0}};
            end
            add_cin_s = 1'b0;
        end
        sum_s = add_a_s + add_b_s + {{WIDTH{1'b0}}, add_cin_s};
    end

    // Sign fix-up of the magnitude result, applied during the FIX cycle.
    always_comb begin
        if (neg_res_r) begin
            prod_fix_s = {(2*WIDTH){1'b0}} - prod_r;
        end else begin
            prod_fix_s = prod_r;
        end
        if (!op_div_r) begin
            hi_fix_s = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_fix_s = prod_fix_s[WIDTH-1:0];
        end else if (dz_r) begin
            hi_fix_s = orig_a_r;
            lo_fix_s = {WIDTH{1'b1}};
        end else begin
            hi_fix_s = magnitude(prod_r[2*WIDTH-1:WIDTH], neg_rem_r);
            lo_fix_s = magnitude(prod_r[WIDTH-1:0], neg_res_r);
        end
    end

    // Sequencer FSM with registered busy/done and the HI/LO register pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CW{1'b0}};
            prod_r    <= {(2*WIDTH){1'b0}};
            opb_r     <= {WIDTH{1'b0}};
            orig_a_r  <= {WIDTH{1'b0}};
            op_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        case (funct)
                            F_MULT, F_MULTU: begin
                                prod_r    <= {{WIDTH{1'b0}}, magnitude(srcb, b_neg_s)};
                                opb_r     <= magnitude(srca, a_neg_s);
                                orig_a_r  <= srca;
                                op_div_r  <= 1'b0;
                                neg_res_r <= a_neg_s ^ b_neg_s;
                                neg_rem_r <= a_neg_s;
                                dz_r      <= (srcb == {WIDTH{1'b0}});
                                cnt_r     <= {CW{1'b0}};
                                busy_r    <= 1'b1;
                                state_r   <= S_MUL;
                            end
                            F_DIV, F_DIVU: begin
                                prod_r    <= {{WIDTH{1'b0}}, magnitude(srca, a_neg_s)};
                                opb_r     <= magnitude(srcb, b_neg_s);
                                orig_a_r  <= srca;
                                op_div_r  <= 1'b1;
                                neg_res_r <= a_neg_s ^ b_neg_s;
                                neg_rem_r <= a_neg_s;
                                dz_r      <= (srcb == {WIDTH{1'b0}});
                                cnt_r     <= {CW{1'b0}};
                                busy_r    <= 1'b1;
                                state_r   <= S_DIV;
                            end
                            F_MTHI: begin
                                hi_r <= srca;
                            end
                            F_MTLO: begin
                                lo_r <= srca;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    if (abort_s) begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        // Add-if-bit-set, then shift the whole accumulator right.
                        prod_r <= {sum_s, prod_r[WIDTH-1:1]};
                        cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        if (cnt_r == CW'(WIDTH - 1)) begin
                            state_r <= S_FIX;
                        end
                    end
                end
                S_DIV: begin
                    if (abort_s) begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        // Restoring step: keep the difference only when it is non-negative.
                        if (!sum_s[WIDTH]) begin
                            prod_r <= {sum_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
                        end else begin
                            prod_r <= {prod_r[2*WIDTH-2:0], 1'b0};
                        end
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        if (cnt_r == CW'(WIDTH - 1)) begin
                            state_r <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (abort_s) begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        hi_r    <= hi_fix_s;
                        lo_r    <= lo_fix_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected {hi,lo} for each
// mult/div; a monitor pops and compares whenever done pulses.
module tb_muldiv_seq;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;
`ifdef MULDIV_ABORT_EN
    logic        abort;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    int          lat;
    int          bcnt;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .funct (funct),
        .srca  (srca),
        .srcb  (srcb),
`ifdef MULDIV_ABORT_EN
        .abort (abort),
`endif
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .rdata (rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                mon_e = exp_q.pop_front();
                check("result_hi", hi, mon_e[63:32]);
                check("result_lo", lo, mon_e[31:0]);
            end
        end
    end

    // Issue one mult/div, scramble inputs after the start edge, wait for done.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          output int latency, output int busy_cycles);
        @(negedge clk);
        start = 1'b1; funct = f; srca = a; srcb = b;
        exp_q.push_back({eh, el});
        latency = 0;
        busy_cycles = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                start = 1'b0; funct = F_MFHI; srca = 32'h5A5A5A5A; srcb = 32'hA5A5A5A5;
            end
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) begin
                latency = i;
                break;
            end
        end
        if (latency == 0) begin
            n_checks++;
            $display("FAIL timeout: got no done within 100 cycles expected done");
        end
    endtask

    task automatic move_to(input logic [5:0] f, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; funct = f; srca = a; srcb = 32'h0;
        @(posedge clk); #1;
        start = 1'b0; funct = F_MFHI;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; funct = 6'b0; srca = 32'h0; srcb = 32'h0;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Arithmetic vectors (back-to-back: each start lands in the done cycle)
        run_op(F_MULT, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, lat, bcnt);
        check("mult_latency", lat, 32'd34);
        check("mult_busy_cycles", bcnt, 32'd33);
        run_op(F_MULTU, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, lat, bcnt);
        run_op(F_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, lat, bcnt);
        run_op(F_DIVU, 32'h7, 32'h2, 32'h1, 32'h3, lat, bcnt);
        check("divu_latency", lat, 32'd34);
        run_op(F_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, lat, bcnt);
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, lat, bcnt);
        run_op(F_DIV, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, lat, bcnt);
        run_op(F_MULT, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'h0, 32'h2A, lat, bcnt);

        // mthi, then mult with an ignored second start; rdata holds old HI until done
        move_to(F_MTHI, 32'hDEADBEEF);
        check("mthi_hi", hi, 32'hDEADBEEF);
        check("mthi_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        start = 1'b1; funct = F_MULT; srca = 32'h5; srcb = 32'h6;
        exp_q.push_back({32'h0, 32'h1E});
        @(posedge clk); #1;
        start = 1'b0; funct = F_MFHI;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; funct = F_DIV; srca = 32'h64; srcb = 32'h7;
        @(posedge clk); #1;
        start = 1'b0; funct = F_MFHI;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin
                lat = 1;
                break;
            end
            check("rdata_old_hi", rdata, 32'hDEADBEEF);
            @(posedge clk); #1;
        end
        check("second_start_done_seen", lat, 32'd1);
        funct = F_MFLO;
        #1;
        check("rdata_mflo", rdata, 32'h1E);
        repeat (40) @(posedge clk);
        #1;
        check("ignored_start_idle", {31'b0, busy}, 32'h0);

        // Synchronous reset in the middle of a mult
        @(negedge clk);
        start = 1'b1; funct = F_MULT; srca = 32'h5; srcb = 32'h6;
        @(posedge clk); #1;
        start = 1'b0; funct = F_MFHI;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_busy", {31'b0, busy}, 32'h0);
        check("midreset_done", {31'b0, done}, 32'h0);
        check("midreset_hi", hi, 32'h0);
        check("midreset_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midreset_idle", {31'b0, busy}, 32'h0);

`ifdef MULDIV_ABORT_EN
        // Abort in the middle of a mult keeps HI/LO
        move_to(F_MTHI, 32'h11);
        move_to(F_MTLO, 32'h22);
        @(negedge clk);
        start = 1'b1; funct = F_MULT; srca = 32'h5; srcb = 32'h6;
        @(posedge clk); #1;
        start = 1'b0; funct = F_MFHI;
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_hi", hi, 32'h11);
        check("abort_lo", lo, 32'h22);
        repeat (40) @(posedge clk);
        #1;
        check("abort_hi_held", hi, 32'h11);
`endif

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS core.
- Executes mult, multu, div, divu over WIDTH+2 cycles using one shared adder/subtractor. Also handles mthi, mtlo, mfhi and mflo.
- Sits beside the ALU in the execute stage, driven by the R-type funct field. The core's controller stalls the PC while busy=1.

Parameters:
- WIDTH, 32, operand/HI/LO width. Iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when state=IDLE
- funct  input  6  R-type funct: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo, 010000 mfhi, 010010 mflo
- srca  input  WIDTH  rs value (multiplicand/dividend; mthi/mtlo data)
- srcb  input  WIDTH  rt value (multiplier/divisor)
- busy  output  1  high while a mult/div is in progress
- done  output  1  one-cycle pulse; HI/LO hold the new result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- rdata  output  WIDTH  combinational: lo when funct=010010, else hi

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset (any state, including mid-operation): state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter and partial registers cleared. No done pulse for the killed operation.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1 with mult/multu/div/divu at edge k:
  - Latch |srca| and |srcb| (two's-complement magnitude for signed ops; raw for unsigned). Latch sign flags and the div-by-zero flag (srcb==0).
  - Go to MUL or DIV with counter=0.
- IDLE, start=1 with mthi/mtlo: hi (or lo) <= srca at that edge. No busy, no done.
- IDLE, start=1 with any other funct: ignored.
- MUL: radix-2 shift-add on magnitudes, one multiplier bit per cycle, 2*WIDTH-bit product accumulator. After WIDTH cycles go to FIX.
- DIV: restoring division on magnitudes, one quotient bit per cycle. After WIDTH cycles go to FIX.
- FIX (1 cycle), writes hi/lo at its end:
  - Signed mult: 2*WIDTH product negated if operand signs differ.
  - Signed div: quotient negated if signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - Divide by zero (signed or unsigned): lo=all ones, hi=original srca; sign fix bypassed.
  - Overflow -2^(WIDTH-1)/-1 falls out naturally: lo=0x80000000, hi=0.
- Latency: busy=1 on edges k+1 .. k+WIDTH+1. At edge k+WIDTH+2: done=1, busy=0, state=IDLE, new hi/lo visible.
- A new start is accepted in the same cycle done=1.
- start while busy=1: ignored. Operands, hi and lo are not disturbed.
- srca/srcb/funct need only be valid in the start cycle.
- hi/lo hold their value between operations. A mult/div overwrites both; mthi/mtlo overwrite one.
- rdata is always combinational, including while busy. It returns the old hi/lo until done.

Optional Feature:
- Macro MULDIV_ABORT_EN.
- When defined: extra input port abort (1 bit). abort=1 while busy=1 returns the FSM to IDLE at that edge; busy=0 next cycle, no done, hi/lo unchanged. This supports exception flush. abort in IDLE has no effect; abort has priority over start in the same cycle.
- When undefined: port absent; every operation runs to completion unless reset.

Test Plan:
- mult srca=0xFFFFFFFE, srcb=0x3 -> done exactly 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high 33 cycles.
- multu srca=0xFFFFFFFE, srcb=0x3 -> hi=0x00000002, lo=0xFFFFFFFA.
- div srca=0xFFFFFFF9 (-7), srcb=0x2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=0x3, hi=0x1.
- divu 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0x0.
- mthi 0xDEADBEEF, then start mult 5*6 and assert start again 3 cycles later with div -> second start ignored; rdata(mfhi)=0xDEADBEEF until done; then hi=0x0, lo=0x1E.
- reset at cycle 10 of a mult -> next cycle busy=0, hi=lo=0, no done. With MULDIV_ABORT_EN: abort at cycle 10 -> busy=0, hi/lo keep prior values, no done.
